// File: rtl/bit_scan_64b_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_scan_64b_if
// Brief    : Mask-in / index-out handshake bundle for bit_scan_64b.
// Revision : 1.0
// ============================================================================
interface bit_scan_64b_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  out_data_o;
    logic        out_last_o;
    logic        out_zero_o;

    // master drives masks and consumes indices; slave is the scanner
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_zero_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, out_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/bit_scan_64b.sv
`default_nettype none
// ============================================================================
// Module   : bit_scan_64b (+ enc_64b)
// Brief    : Walks a 64-bit mask highest-set-bit first, one index per beat.
//            Define BIT_SCAN_ZERO_EN to emit a single zero-flagged beat for
//            an all-zero mask instead of silently dropping it.
// Revision : 1.0
// ============================================================================

// Registered highest-set-bit encoder; result valid the cycle after init_i.
module enc_64b (
    input  wire         clk_i,
    input  wire         rst_n_i,
    input  wire         init_i,
    input  wire  [63:0] data_i,
    output logic        done_o,
    output logic [5:0]  data_o
);
    logic [5:0] w_idx;
    logic       r_done;
    logic [5:0] r_idx;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (data_i[i]) w_idx = 6'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_done <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_done <= init_i;
            if (init_i) r_idx <= w_idx;
        end
    end

    assign done_o = r_done;
    assign data_o = r_idx;
endmodule

module bit_scan_64b (
    input  wire           clk_i,
    input  wire           rst_n_i,
    bit_scan_64b_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_mask;
    logic [5:0]  r_out_data;
    logic        r_out_last;
    logic        w_enc_init;
    logic        w_enc_done;
    logic [5:0]  w_enc_idx;
    logic [63:0] w_clr_onehot;
    logic [63:0] w_mask_cleared;

    assign w_enc_init     = (r_state == S_REQ);
    assign w_clr_onehot   = 64'd1 << w_enc_idx;
    assign w_mask_cleared = r_mask & ~w_clr_onehot;

    enc_64b u_enc (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (w_enc_init),
        .data_i  (r_mask),
        .done_o  (w_enc_done),
        .data_o  (w_enc_idx)
    );

`ifdef BIT_SCAN_ZERO_EN
    logic r_out_zero;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
`ifdef BIT_SCAN_ZERO_EN
            r_out_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        r_mask <= bus.in_data_i;
                        if (|bus.in_data_i) begin
                            r_state <= S_REQ;
                        end
`ifdef BIT_SCAN_ZERO_EN
                        else begin
                            r_out_data <= '0;
                            r_out_last <= 1'b1;
                            r_out_zero <= 1'b1;
                            r_state    <= S_OUT;
                        end
`endif
                    end
                end
                S_REQ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_enc_done) begin
                        r_out_data <= w_enc_idx;
                        r_mask     <= w_mask_cleared;
                        r_out_last <= (w_mask_cleared == 64'd0);
`ifdef BIT_SCAN_ZERO_EN
                        r_out_zero <= 1'b0;
`endif
                        r_state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    // beat is held until taken; encoder stays idle meanwhile
                    if (bus.out_ready_i) begin
                        r_state <= r_out_last ? S_IDLE : S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_OUT);
    assign bus.out_data_o  = r_out_data;
    assign bus.out_last_o  = r_out_last;
`ifdef BIT_SCAN_ZERO_EN
    assign bus.out_zero_o  = r_out_zero;
`else
    assign bus.out_zero_o  = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bit_scan_64b.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_scan_64b
// Brief    : Directed and randomized checks of bit_scan_64b against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_bit_scan_64b;
    typedef struct packed {
        logic [5:0] d;
        logic       l;
        logic       z;
    } beat_t;

    typedef struct {
        beat_t b;
        int    c;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    bit_scan_64b_if bus ();

    bit_scan_64b dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pending beats for the current mask plus the cycle
    // in which the head beat is due to appear.
    beat_t mq[$];
    rec_t  lq[$];
    bit    busy     = 1'b0;
    int    due      = 0;
    int    last_acc = 0;

    always @(negedge clk) begin
        bit exp_v;
        if (!rst_n) begin
            mq.delete();
            busy = 1'b0;
        end else begin
            exp_v = busy && (cyc >= due);
            chk("in_ready", 64'(bus.in_ready_o), 64'(!busy));
            chk("out_valid", 64'(bus.out_valid_o), 64'(exp_v));
            if (exp_v) begin
                chk("out_data", 64'(bus.out_data_o), 64'(mq[0].d));
                chk("out_last", 64'(bus.out_last_o), 64'(mq[0].l));
                chk("out_zero", 64'(bus.out_zero_o), 64'(mq[0].z));
            end
            if (bus.out_valid_o && bus.out_ready_i)
                lq.push_back('{b: '{d: bus.out_data_o, l: bus.out_last_o, z: bus.out_zero_o}, c: cyc});
            if (bus.in_valid_i && bus.in_ready_o) last_acc = cyc;

            if (!busy && bus.in_valid_i) begin
                if (bus.in_data_i == 64'd0) begin
`ifdef BIT_SCAN_ZERO_EN
                    mq.push_back('{d: 6'd0, l: 1'b1, z: 1'b1});
                    busy = 1'b1;
                    due  = cyc + 1;
`endif
                end else begin
                    int left;
                    left = $countones(bus.in_data_i);
                    for (int b = 63; b >= 0; b--) begin
                        if (bus.in_data_i[b]) begin
                            left--;
                            mq.push_back('{d: 6'(b), l: (left == 0), z: 1'b0});
                        end
                    end
                    busy = 1'b1;
                    due  = cyc + 3;
                end
            end else if (exp_v && bus.out_ready_i) begin
                void'(mq.pop_front());
                if (mq.size() == 0) busy = 1'b0;
                else                due  = cyc + 3;
            end
        end
    end

    task automatic send(input logic [63:0] m);
        int n = 0;
        @(posedge clk); #1;
        while (!bus.in_ready_o && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("send_timeout", 64'd1, 64'd0);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = m;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready_o),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
        chk({tag, "_out_data"},  64'(bus.out_data_o),  64'd0);
        chk({tag, "_out_last"},  64'(bus.out_last_o),  64'd0);
        chk({tag, "_out_zero"},  64'(bus.out_zero_o),  64'd0);
    endtask

    function automatic logic [63:0] rand_mask();
        logic [63:0] m;
        case ($urandom_range(0, 5))
            0:       m = 64'd0;
            1:       m = 64'd1 << $urandom_range(0, 63);
            2:       m = {$urandom, $urandom};
            3:       m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            4:       m = '1;
            default: m = {$urandom_range(0, 7), 58'd0, $urandom_range(0, 63)};
        endcase
        return m;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // single top bit
        lq.delete();
        send(64'h8000_0000_0000_0000);
        wait_idle(300);
        chk("single_count", 64'(lq.size()), 64'd1);
        if (lq.size() == 1) begin
            chk("single_data", 64'(lq[0].b.d), 64'd63);
            chk("single_last", 64'(lq[0].b.l), 64'd1);
            chk("single_lat",  64'(lq[0].c - last_acc), 64'd3);
        end

        // two bits
        lq.delete();
        send(64'h0000_0000_0000_0005);
        wait_idle(300);
        chk("two_count", 64'(lq.size()), 64'd2);
        if (lq.size() == 2) begin
            chk("two_d0", 64'(lq[0].b.d), 64'd2);
            chk("two_l0", 64'(lq[0].b.l), 64'd0);
            chk("two_c0", 64'(lq[0].c - last_acc), 64'd3);
            chk("two_d1", 64'(lq[1].b.d), 64'd0);
            chk("two_l1", 64'(lq[1].b.l), 64'd1);
            chk("two_c1", 64'(lq[1].c - last_acc), 64'd6);
        end

        // all ones
        lq.delete();
        send('1);
        wait_idle(400);
        chk("ones_count", 64'(lq.size()), 64'd64);
        if (lq.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("ones_data", 64'(lq[i].b.d), 64'(63 - i));
                chk("ones_last", 64'(lq[i].b.l), 64'(i == 63));
                chk("ones_time", 64'(lq[i].c - last_acc), 64'(3 + 3 * i));
            end
        end

        // backpressure held for 10 cycles on the first beat
        lq.delete();
        @(posedge clk); #1 bus.out_ready_i = 1'b0;
        send(64'h0000_0100_0000_0010);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.out_valid_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("bp_valid_timeout", 64'd0, 64'd1);
        end
        repeat (10) @(posedge clk);
        #1 bus.out_ready_i = 1'b1;
        wait_idle(300);
        chk("bp_count", 64'(lq.size()), 64'd2);
        if (lq.size() == 2) begin
            chk("bp_d0",  64'(lq[0].b.d), 64'd40);
            chk("bp_c0",  64'(lq[0].c - last_acc), 64'd13);
            chk("bp_d1",  64'(lq[1].b.d), 64'd4);
            chk("bp_gap", 64'(lq[1].c - lq[0].c), 64'd3);
        end

        // all-zero mask
        lq.delete();
        send(64'd0);
        wait_idle(50);
        repeat (3) @(negedge clk);
`ifdef BIT_SCAN_ZERO_EN
        chk("zero_count", 64'(lq.size()), 64'd1);
        if (lq.size() == 1) begin
            chk("zero_data", 64'(lq[0].b.d), 64'd0);
            chk("zero_last", 64'(lq[0].b.l), 64'd1);
            chk("zero_flag", 64'(lq[0].b.z), 64'd1);
            chk("zero_lat",  64'(lq[0].c - last_acc), 64'd1);
        end
`else
        chk("zero_count", 64'(lq.size()), 64'd0);
        chk("zero_ready", 64'(bus.in_ready_o), 64'd1);
`endif

        // reset during WAIT of an all-ones scan
        send('1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        lq.delete();
        repeat (5) @(negedge clk);
        chk("midrst_no_beat", 64'(lq.size()), 64'd0);
        send(64'd1);
        wait_idle(300);
        chk("midrst_count", 64'(lq.size()), 64'd1);
        if (lq.size() == 1) begin
            chk("midrst_data", 64'(lq[0].b.d), 64'd0);
            chk("midrst_last", 64'(lq[0].b.l), 64'd1);
            chk("midrst_lat",  64'(lq[0].c - last_acc), 64'd3);
        end

        // randomized traffic: busy-time in_valid must be ignored
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            bus.in_valid_i  = ($urandom_range(0, 3) == 0);
            bus.in_data_i   = rand_mask();
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        wait_idle(400);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
